ni_tx_packetizer: RTL
=====================

# ni_tx_packetizer

Network-interface transmit packetizer: drains 64-bit payload words from the read side of a `gp_fifo` and emits them toward the local router port as a packet of 66-bit flits. Each packet is one head flit followed by `PKT_WORDS` payload flits, the last one marked tail. It sits between the NI egress `gp_fifo` (which the core writes) and the router injection port, acting as the FIFO's reader.

## Interface
- `PKT_WORDS`, default 4: payload words per packet; legal range 1–15.
- `SRC_ID`, default 8'h00: this node's ID, placed in every head flit.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `fifo_empty` in 1: `gp_fifo` empty flag.
- `fifo_ocup` in 5: `gp_fifo` occupancy, 0–16.
- `fifo_data` in 64: `gp_fifo` data_out; valid the cycle after a `fifo_read_en` pulse.
- `fifo_read_en` out 1: single-cycle pop strobe.
- `dest_id` in 8: destination node; sampled when a packet starts.
- `flit_out` out 66: bits [65:64] are the type (01 head, 00 body, 10 tail); bits [63:0] are the payload.
- `flit_valid` out 1: flit presented.
- `flit_ready` in 1: router accepts; transfer occurs when valid & ready at a rising edge.
- `pkt_count` out 16: packets fully sent; wraps.
- `underflow_err` out 1: sticky; set if a pop is issued while `fifo_empty`=1.

## Operation
- FSM states: IDLE, HEAD, POP, WAIT, SEND.
- **IDLE**
  - If `fifo_ocup >= PKT_WORDS` and `!fifo_empty`: latch `dest_id`, load `words_left` = PKT_WORDS, go to HEAD.
  - A packet never starts without all of its words present.
- **HEAD**
  - `flit_valid`=1.
  - `flit_out` = {2'b01, dest_id_q[63:56], SRC_ID[55:48], PKT_WORDS[47:40], 24'h0, seq[15:0]}.
  - On handshake, go to POP.
- **POP**
  - `fifo_read_en`=1 for exactly this cycle.
  - If `fifo_empty`=1 here, set `underflow_err` and continue.
  - Go to WAIT.
- **WAIT**
  - Capture `fifo_data` into the flit register at the end of the cycle.
  - Type is tail if `words_left`==1, else body.
  - Go to SEND.
- **SEND**
  - `flit_valid`=1; hold until handshake.
  - On handshake, decrement `words_left`.
  - If the result is 0: increment `pkt_count` and `seq`, go to IDLE. Otherwise go to POP.
- While `flit_valid`=1 and `flit_ready`=0, `flit_out` is held stable; valid never drops without a transfer.
- `seq` is an internal 16-bit counter, equal to `pkt_count`, wrapping from FFFF to 0000.
- `fifo_ocup` and `fifo_empty` are ignored outside IDLE and POP.
- `dest_id` changes mid-packet have no effect.

## Timing
- **Reset values**
  - State IDLE; `fifo_read_en`=0, `flit_valid`=0, `flit_out`=0.
  - `pkt_count`=0, `seq`=0, `underflow_err`=0, `words_left`=0.
- **Reset asserted mid-packet:** outputs return to reset values immediately (asynchronous). Popped-but-unsent words are lost. No partial tail is emitted.
- **Start latency:** start condition true in IDLE at cycle T → head `flit_valid`=1 in T+1.
- **Per payload word:** head or previous flit handshake at edge E → `fifo_read_en` high in cycle E+1 → data captured in cycle E+2 → `flit_valid` in cycle E+3.
  - Minimum 3 cycles per payload flit with `flit_ready` held at 1.
  - Minimum packet duration is 1 + 3·PKT_WORDS cycles.
- **Back-to-back packets:** IDLE costs one cycle between the tail handshake and the next head.
- `pkt_count` updates on the tail-handshake edge.
- **`flit_ready` asserted with `flit_valid`=0:** no effect.
- **Simultaneous core write during POP:** ignored; the FIFO handles it.

## Structure
- Package `ni_pkg` holds:
  - FLIT_W=66 and FLIT_TYPE_HEAD/BODY/TAIL.
  - The head-field bit positions.
  - The state enumeration.
- The router input side and the future `ni_rx_depacketizer` share the same package.
- Single module; no sub-module. `gp_fifo` is instantiated by the NI top, not inside this block.

## Test plan
- **Reset then 4 words:** reset, then preload 4 words 64'h1…64'h4 with `flit_ready`=1 and `dest_id`=8'h23.
  - Flits are head {01, 23, 00, 04, 0, 0000}, then body 1, body 2, body 3, tail 4.
  - `pkt_count`=1.
  - Head appears 1 cycle after `ocup`=4; flits are spaced 3 cycles apart.
- **Below threshold:** load 3 words. No `flit_valid` and no `fifo_read_en` for 20 cycles. Writing a 4th word starts the packet.
- **Backpressure:** hold `flit_ready`=0 for 5 cycles during body 2.
  - `flit_out` and `flit_valid` are stable throughout.
  - No extra `fifo_read_en` is issued.
  - Resumes correctly after release.
- **Back-to-back:** preload 8 words.
  - Two packets with `seq` 0 and 1, exactly one IDLE cycle between them.
  - `pkt_count`=2; `ocup` ends at 0.
- **Reset mid-packet:** assert `reset` while in SEND of body 2.
  - `flit_valid` drops immediately; `pkt_count`=0.
  - After release with 4 fresh words, a clean packet with `seq` 0 is sent.
- **Underflow:** force `fifo_empty`=1 during POP. `underflow_err`=1 and stays set until reset.

Source files
------------

// File: rtl/ni_pkg.sv
// Shared NI definitions: flit format, head-field layout and packetizer state encoding.
// Used by the TX packetizer, the router input side and the RX depacketizer.
package ni_pkg;

  localparam int unsigned FLIT_W    = 66;
  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned NODE_W    = 8;
  localparam int unsigned SEQ_W     = 16;

  localparam logic [TYPE_W-1:0] FLIT_TYPE_HEAD = 2'b01;
  localparam logic [TYPE_W-1:0] FLIT_TYPE_BODY = 2'b00;
  localparam logic [TYPE_W-1:0] FLIT_TYPE_TAIL = 2'b10;

  // Head-flit field positions inside the 64-bit payload
  localparam int unsigned HEAD_DEST_LSB = 56;
  localparam int unsigned HEAD_SRC_LSB  = 48;
  localparam int unsigned HEAD_LEN_LSB  = 40;
  localparam int unsigned HEAD_SEQ_LSB  = 0;

  typedef struct packed {
    logic [TYPE_W-1:0]    ftype;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_POP,
    ST_WAIT,
    ST_SEND
  } tx_state_e;

  function automatic flit_t make_head(input logic [NODE_W-1:0] dest,
                                      input logic [NODE_W-1:0] src,
                                      input logic [7:0]        len,
                                      input logic [SEQ_W-1:0]  seq);
    flit_t f;
    f                                 = '0;
    f.ftype                           = FLIT_TYPE_HEAD;
    f.payload[HEAD_DEST_LSB +: NODE_W] = dest;
    f.payload[HEAD_SRC_LSB  +: NODE_W] = src;
    f.payload[HEAD_LEN_LSB  +: 8]      = len;
    f.payload[HEAD_SEQ_LSB  +: SEQ_W]  = seq;
    return f;
  endfunction

endpackage

// File: rtl/ni_tx_packetizer_if.sv
// FIFO read side plus router injection port seen by the TX packetizer.
// master = packetizer, slave = FIFO/router environment.
interface ni_tx_packetizer_if;
  import ni_pkg::*;

  logic                 fifo_empty;
  logic [4:0]           fifo_ocup;
  logic [PAYLOAD_W-1:0] fifo_data;
  logic                 fifo_read_en;
  logic [NODE_W-1:0]    dest_id;
  flit_t                flit_out;
  logic                 flit_valid;
  logic                 flit_ready;

  modport master (
    input  fifo_empty, fifo_ocup, fifo_data, dest_id, flit_ready,
    output fifo_read_en, flit_out, flit_valid
  );

  modport slave (
    output fifo_empty, fifo_ocup, fifo_data, dest_id, flit_ready,
    input  fifo_read_en, flit_out, flit_valid
  );

endinterface

// File: rtl/ni_tx_packetizer.sv
// NI transmit packetizer: pops PKT_WORDS words from gp_fifo and emits head + body/tail flits.
// A packet only starts once every one of its words is already in the FIFO.
module ni_tx_packetizer
  import ni_pkg::*;
#(
  parameter int unsigned       PKT_WORDS = 4,
  parameter logic [NODE_W-1:0] SRC_ID    = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  ni_tx_packetizer_if.master  bus,
  output logic [SEQ_W-1:0]    pkt_count,
  output logic                underflow_err
);

  localparam int unsigned        CNT_W     = 4;
  localparam logic [CNT_W-1:0]   WORDS_C   = CNT_W'(PKT_WORDS);
  localparam logic [4:0]         OCUP_THR  = 5'(PKT_WORDS);
  localparam logic [7:0]         LEN_FIELD = 8'(PKT_WORDS);

  tx_state_e         state;
  logic [CNT_W-1:0]  words_left;
  logic [SEQ_W-1:0]  seq;
  flit_t             flit_q;
  logic              valid_q;
  logic              read_en_q;

  assign bus.flit_out     = flit_q;
  assign bus.flit_valid   = valid_q;
  assign bus.fifo_read_en = read_en_q;
  // Sequence number and sent-packet count always advance together
  assign pkt_count        = seq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      words_left    <= '0;
      seq           <= '0;
      flit_q        <= '0;
      valid_q       <= 1'b0;
      read_en_q     <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      read_en_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // dest_id is captured straight into the head flit; later changes are ignored
          if ((bus.fifo_ocup >= OCUP_THR) && !bus.fifo_empty) begin
            words_left <= WORDS_C;
            flit_q     <= make_head(bus.dest_id, SRC_ID, LEN_FIELD, seq);
            valid_q    <= 1'b1;
            state      <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (bus.flit_ready) begin
            valid_q   <= 1'b0;
            read_en_q <= 1'b1;
            state     <= ST_POP;
          end
        end
        ST_POP: begin
          if (bus.fifo_empty) underflow_err <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          flit_q.ftype   <= (words_left == CNT_W'(1)) ? FLIT_TYPE_TAIL : FLIT_TYPE_BODY;
          flit_q.payload <= bus.fifo_data;
          valid_q        <= 1'b1;
          state          <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.flit_ready) begin
            valid_q    <= 1'b0;
            words_left <= words_left - CNT_W'(1);
            if (words_left == CNT_W'(1)) begin
              seq   <= seq + SEQ_W'(1);
              state <= ST_IDLE;
            end else begin
              read_en_q <= 1'b1;
              state     <= ST_POP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
